hdr_engine_sched: RTL and testbench
===================================

// Module: hdr_engine_sched
// PURPOSE
// - Sequences one HDR-DDR command at a time between two engines: normal transfer (eng0) and CCC_Handler (eng1).
// - Routes the granted engine's control bundle onto the shared datapath: tx, rx, bits_counter, scl staller,
//   frame counter, sda pp/od select and regfile port.
// - Supervises each command with a watchdog and rx-error abort, then requests HDR exit/restart when needed.
// - Sits between the command-descriptor regfile and the engines, one level below the top controller FSM.
// PARAMETERS
// - ADDR_W      16    regfile address width inside ctrl bundle
// - TIMEOUT_CYC 4096  max sys-clk cycles an engine may run; 0 disables the watchdog
// - TO_CNT_W    13    watchdog counter width; must satisfy 2**TO_CNT_W > TIMEOUT_CYC
// PORTS
// - i_sys_clk        in   1        system clock
// - i_sys_rst        in   1        synchronous reset, active-high
// - i_cmd_valid      in   1        command descriptor ready in regfile
// - i_regf_CP        in   1        1 = CCC command (eng1), 0 = normal transfer (eng0)
// - i_regf_TOC       in   1        last command: exit HDR after completion
// - o_cmd_ack        out  1        1-cycle pulse: descriptor accepted
// - o_eng_en         out  2        one-hot engine enable (engine_en to eng0/eng1)
// - i_eng_done       in   2        per-engine done (o_engine_done)
// - i_eng0_ctrl      in   CTRL_W   eng0 shared-datapath control bundle (ctrl_bus_t)
// - i_eng1_ctrl      in   CTRL_W   eng1 shared-datapath control bundle
// - o_shared_ctrl    out  CTRL_W   bundle driven to tx/rx/bitcnt/sclstall/frmcnt/regf
// - i_rx_error       in   1        rx framing/parity error
// - o_exit_en        out  1        request HDR exit/restart pattern
// - i_exit_done      in   1        exit/restart pattern finished
// - o_busy           out  1        state != IDLE
// - o_xfer_done      out  1        1-cycle pulse: command finished (ok or error)
// - o_err_code       out  2        00 none, 01 rx_error, 10 timeout; valid with o_xfer_done
// BEHAVIOUR
// - Reset: state IDLE. o_eng_en=0, o_cmd_ack=0, o_exit_en=0, o_busy=0, o_xfer_done=0, o_err_code=0.
//   Also o_shared_ctrl=CTRL_IDLE (all enables 0, pp_od=0 open-drain) and watchdog=0.
//   Reset mid-command forces the same state on the next edge.
// - FSM states: IDLE, DECODE, RUN, DONE, ABORT, EXIT.
//   - IDLE:   i_cmd_valid -> DECODE; latch CP into grant and TOC into toc_q; o_cmd_ack pulses in DECODE.
//   - DECODE: -> RUN; o_eng_en[grant] asserted from RUN entry, i.e. 2 cycles after i_cmd_valid is sampled.
//   - RUN:    o_eng_en held. Exits in priority order:
//       - i_rx_error -> ABORT with err=01.
//       - watchdog==TIMEOUT_CYC-1 -> ABORT with err=10.
//       - i_eng_done[grant] -> DONE.
//     - Error beats done in the same cycle. i_eng_done of the non-granted engine is ignored.
//   - DONE:   o_eng_en=0; o_xfer_done pulse with err=00; toc_q ? EXIT : IDLE.
//   - ABORT:  o_eng_en=0 and shared bus CTRL_IDLE for 1 cycle; o_xfer_done pulses with err code; -> EXIT always.
//   - EXIT:   o_exit_en held high until i_exit_done is sampled high, then IDLE; clears toc_q.
// - Mux: o_shared_ctrl = grant's i_engN_ctrl, combinational from registered grant, only while state==RUN.
//   Otherwise CTRL_IDLE. No added latency on engine->datapath path.
// - Watchdog: cleared on RUN entry, +1 per RUN cycle, cannot wrap (ABORT first); inactive when TIMEOUT_CYC==0.
// - i_cmd_valid outside IDLE: ignored, no ack. Back-to-back commands: IDLE->DECODE on the cycle after DONE.
// - o_err_code holds its value until the next o_xfer_done.
// STRUCTURE
// - Package hdr_sched_pkg defines:
//   - ctrl_bus_t: packed tx_en, tx_mode[3:0], rx_en, rx_mode[2:0], bitcnt_en, frmcnt_en, sclstall_en,
//     sclstall_code[3:0], sdahand_pp_od, regf_wr_en, regf_rd_en, regf_addr[ADDR_W-1:0], txrx_addr_ccc[7:0].
//   - CTRL_W, CTRL_IDLE, sched_state_e, err codes ERR_NONE, ERR_RX, ERR_TO.
// - Single module; watchdog kept inline, no sub-module.
// TESTING
// - CCC path: CP=1, TOC=0, eng1 done after 300 cyc.
//   -> ack 1 cyc after valid, o_eng_en=2'b10, bus==i_eng1_ctrl, xfer_done err=00, o_exit_en never set.
// - Normal path: CP=0, TOC=1, eng0 done.
//   -> o_eng_en=2'b01; DONE then EXIT; o_exit_en high until i_exit_done at +20 cyc; then IDLE, o_busy=0.
// - Error: i_rx_error and i_eng_done[1] in same RUN cycle.
//   -> ABORT, err=01, bus CTRL_IDLE next cycle, EXIT entered although TOC=0.
// - Timeout: TIMEOUT_CYC=16, engine never done.
//   -> ABORT exactly 16 RUN cycles after entry, err=10; eng0 done during eng1 grant causes no effect.
// - Busy/reset: i_cmd_valid pulsed during RUN -> no ack.
//   - i_sys_rst mid-RUN -> all outputs at reset values on next edge, o_shared_ctrl==CTRL_IDLE.

Source files
------------

// File: rtl/hdr_sched_pkg.sv
// Shared types for the HDR-DDR command scheduler: engine control bundle, FSM states, error codes.
package hdr_sched_pkg;

  localparam int REGF_ADDR_W = 16;

  typedef struct packed {
    logic                   tx_en;
    logic [3:0]             tx_mode;
    logic                   rx_en;
    logic [2:0]             rx_mode;
    logic                   bitcnt_en;
    logic                   frmcnt_en;
    logic                   sclstall_en;
    logic [3:0]             sclstall_code;
    logic                   sdahand_pp_od;
    logic                   regf_wr_en;
    logic                   regf_rd_en;
    logic [REGF_ADDR_W-1:0] regf_addr;
    logic [7:0]             txrx_addr_ccc;
  } ctrl_bus_t;

  localparam int CTRL_W = $bits(ctrl_bus_t);

  // Everything off, SDA in open-drain mode.
  localparam ctrl_bus_t CTRL_IDLE = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_RUN,
    S_DONE,
    S_ABORT,
    S_EXIT
  } sched_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_RX   = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;

endpackage

// File: rtl/hdr_engine_sched.sv
// Grants one HDR-DDR engine per command, muxes its control bundle onto the shared datapath,
// and supervises it with a watchdog and rx-error abort before requesting HDR exit.
module hdr_engine_sched
  import hdr_sched_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_CNT_W    = 13
) (
  input  logic          i_sys_clk,
  input  logic          i_sys_rst,
  input  logic          i_cmd_valid,
  input  logic          i_regf_CP,
  input  logic          i_regf_TOC,
  output logic          o_cmd_ack,
  output logic [1:0]    o_eng_en,
  input  logic [1:0]    i_eng_done,
  input  ctrl_bus_t     i_eng0_ctrl,
  input  ctrl_bus_t     i_eng1_ctrl,
  output ctrl_bus_t     o_shared_ctrl,
  input  logic          i_rx_error,
  output logic          o_exit_en,
  input  logic          i_exit_done,
  output logic          o_busy,
  output logic          o_xfer_done,
  output logic [1:0]    o_err_code
);

  if ((ADDR_W != REGF_ADDR_W) || ((2 ** TO_CNT_W) <= TIMEOUT_CYC)) begin : g_param_check
    $error("hdr_engine_sched: ADDR_W must match the package bundle and 2**TO_CNT_W must exceed TIMEOUT_CYC");
  end

  sched_state_e        state, state_nx;
  logic                grant;
  logic                toc_q;
  logic [1:0]          err_q;
  logic [TO_CNT_W-1:0] wd;
  logic                wd_hit;
  logic                done_g;

  // A zero timeout disables the watchdog entirely.
  assign wd_hit = (TIMEOUT_CYC != 0) && (wd == TO_CNT_W'(TIMEOUT_CYC - 1));
  assign done_g = i_eng_done[grant];

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state <= S_IDLE;
      grant <= 1'b0;
      toc_q <= 1'b0;
      err_q <= ERR_NONE;
      wd    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && i_cmd_valid) begin
        grant <= i_regf_CP;
        toc_q <= i_regf_TOC;
      end
      if (state == S_EXIT && i_exit_done) toc_q <= 1'b0;
      if (state == S_DECODE) wd <= '0;
      else if (state == S_RUN && TIMEOUT_CYC != 0) wd <= wd + 1'b1;
      // Error sources outrank a same-cycle done.
      if (state == S_RUN) begin
        if (i_rx_error)  err_q <= ERR_RX;
        else if (wd_hit) err_q <= ERR_TO;
        else if (done_g) err_q <= ERR_NONE;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    o_cmd_ack     = 1'b0;
    o_eng_en      = 2'b00;
    o_shared_ctrl = CTRL_IDLE;
    o_exit_en     = 1'b0;
    o_xfer_done   = 1'b0;
    o_busy        = (state != S_IDLE);
    o_err_code    = err_q;
    case (state)
      S_IDLE:   if (i_cmd_valid) state_nx = S_DECODE;
      S_DECODE: begin
        o_cmd_ack = 1'b1;
        state_nx  = S_RUN;
      end
      S_RUN: begin
        o_eng_en      = grant ? 2'b10 : 2'b01;
        o_shared_ctrl = grant ? i_eng1_ctrl : i_eng0_ctrl;
        if (i_rx_error || wd_hit) state_nx = S_ABORT;
        else if (done_g)          state_nx = S_DONE;
      end
      S_DONE: begin
        o_xfer_done = 1'b1;
        state_nx    = toc_q ? S_EXIT : S_IDLE;
      end
      S_ABORT: begin
        o_xfer_done = 1'b1;
        state_nx    = S_EXIT;
      end
      S_EXIT: begin
        o_exit_en = 1'b1;
        if (i_exit_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hdr_engine_sched.sv
// Self-checking bench for hdr_engine_sched: table-driven command vectors plus randomized commands.
module tb_hdr_engine_sched;
  import hdr_sched_pkg::*;

  localparam int MAIN_TO = 1024;
  localparam int SMALL_TO = 16;

  typedef struct {
    int sel;   // 0: main instance, 1: short-timeout instance
    int cp;
    int toc;
    int d;     // RUN cycle index where granted done rises, -1 never
    int r;     // RUN cycle index where rx error rises, -1 never
    int xd;    // cycles of o_exit_en before i_exit_done
    int len;   // expected RUN cycles
    int err;
    int ex;    // expected EXIT visit
  } vec_t;

  logic      clk = 1'b0;
  logic      rst;
  logic      cmd_valid, cp, toc, rx_error, exit_done;
  logic [1:0] eng_done;
  ctrl_bus_t eng0_ctrl, eng1_ctrl;
  logic      sel_to;

  logic      ack_a, ack_b, exit_a, exit_b, busy_a, busy_b, xd_a, xd_b;
  logic [1:0] en_a, en_b, err_a, err_b;
  ctrl_bus_t sh_a, sh_b;

  logic      ack, exit_en, busy, xfer_done;
  logic [1:0] eng_en, err_code;
  ctrl_bus_t shared;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hdr_engine_sched #(.ADDR_W(16), .TIMEOUT_CYC(MAIN_TO), .TO_CNT_W(13)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_cmd_valid(cmd_valid), .i_regf_CP(cp),
    .i_regf_TOC(toc), .o_cmd_ack(ack_a), .o_eng_en(en_a), .i_eng_done(eng_done),
    .i_eng0_ctrl(eng0_ctrl), .i_eng1_ctrl(eng1_ctrl), .o_shared_ctrl(sh_a),
    .i_rx_error(rx_error), .o_exit_en(exit_a), .i_exit_done(exit_done),
    .o_busy(busy_a), .o_xfer_done(xd_a), .o_err_code(err_a));

  hdr_engine_sched #(.ADDR_W(16), .TIMEOUT_CYC(SMALL_TO), .TO_CNT_W(5)) dut_to (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_cmd_valid(cmd_valid), .i_regf_CP(cp),
    .i_regf_TOC(toc), .o_cmd_ack(ack_b), .o_eng_en(en_b), .i_eng_done(eng_done),
    .i_eng0_ctrl(eng0_ctrl), .i_eng1_ctrl(eng1_ctrl), .o_shared_ctrl(sh_b),
    .i_rx_error(rx_error), .o_exit_en(exit_b), .i_exit_done(exit_done),
    .o_busy(busy_b), .o_xfer_done(xd_b), .o_err_code(err_b));

  assign ack       = sel_to ? ack_b  : ack_a;
  assign eng_en    = sel_to ? en_b   : en_a;
  assign shared    = sel_to ? sh_b   : sh_a;
  assign exit_en   = sel_to ? exit_b : exit_a;
  assign busy      = sel_to ? busy_b : busy_a;
  assign xfer_done = sel_to ? xd_b   : xd_a;
  assign err_code  = sel_to ? err_b  : err_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Outcome of one command from the priority rules: rx error, then timeout, then granted done.
  function automatic void model(input int d, input int r, input int t, input int tc,
                                output int len, output int err, output int ex);
    int idx;
    idx = 1 << 30;
    err = 0;
    if (r >= 0) begin idx = r; err = 1; end
    if (t > 0 && (t - 1) < idx) begin idx = t - 1; err = 2; end
    if (d >= 0 && d < idx) begin idx = d; err = 0; end
    len = idx + 1;
    ex  = (tc != 0 || err != 0) ? 1 : 0;
  endfunction

  task automatic randomize_ctrl();
    logic [63:0] t0, t1;
    t0 = {$urandom(), $urandom()};
    t1 = {$urandom(), $urandom()};
    eng0_ctrl = ctrl_bus_t'(t0[CTRL_W-1:0]);
    eng1_ctrl = ctrl_bus_t'(t1[CTRL_W-1:0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"},    64'(ack), 64'(0));
    chk({tag, "_en"},     64'(eng_en), 64'(0));
    chk({tag, "_exit"},   64'(exit_en), 64'(0));
    chk({tag, "_busy"},   64'(busy), 64'(0));
    chk({tag, "_xdone"},  64'(xfer_done), 64'(0));
    chk({tag, "_err"},    64'(err_code), 64'(0));
    chk({tag, "_shared"}, 64'(shared), 64'(CTRL_IDLE));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; eng_done = 2'b00; rx_error = 1'b0; exit_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v);
    ctrl_bus_t exp_bus;
    @(negedge clk);
    cmd_valid = 1'b1; cp = v.cp[0]; toc = v.toc[0];
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ack", 64'(ack), 64'(1));
    chk("decode_en", 64'(eng_en), 64'(0));
    chk("decode_busy", 64'(busy), 64'(1));
    for (int n = 0; n < v.len; n++) begin
      @(negedge clk);
      randomize_ctrl();
      eng_done[v.cp]     = (n == v.d);
      eng_done[1 - v.cp] = 1'($urandom_range(0, 1));
      rx_error           = (n == v.r);
      cmd_valid          = ($urandom_range(0, 7) == 0);
      #1;
      exp_bus = (v.cp != 0) ? eng1_ctrl : eng0_ctrl;
      chk("run_en", 64'(eng_en), (v.cp != 0) ? 64'h2 : 64'h1);
      chk("run_bus", 64'(shared), 64'(exp_bus));
      chk("run_ack", 64'(ack), 64'(0));
      chk("run_xdone", 64'(xfer_done), 64'(0));
    end
    @(negedge clk);
    eng_done = 2'b00; rx_error = 1'b0; cmd_valid = 1'b0;
    chk("end_xdone", 64'(xfer_done), 64'(1));
    chk("end_err", 64'(err_code), 64'(v.err));
    chk("end_en", 64'(eng_en), 64'(0));
    chk("end_bus", 64'(shared), 64'(CTRL_IDLE));
    chk("end_ack", 64'(ack), 64'(0));
    if (v.ex != 0) begin
      for (int k = 0; k <= v.xd; k++) begin
        @(negedge clk);
        chk("exit_en", 64'(exit_en), 64'(1));
        chk("exit_xdone", 64'(xfer_done), 64'(0));
        exit_done = (k == v.xd);
      end
      @(negedge clk);
      exit_done = 1'b0;
    end else begin
      @(negedge clk);
    end
    chk("idle_exit", 64'(exit_en), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("err_hold", 64'(err_code), 64'(v.err));
  endtask

  vec_t tbl[4];
  vec_t rv;
  int   len_m, err_m, ex_m;

  initial begin
    sel_to = 1'b0; rst = 1'b1; cmd_valid = 1'b0; cp = 1'b0; toc = 1'b0;
    eng_done = 2'b00; rx_error = 1'b0; exit_done = 1'b0;
    eng0_ctrl = CTRL_IDLE; eng1_ctrl = CTRL_IDLE;

    //          sel cp toc   d    r  xd  len err ex
    tbl[0] = '{0, 1, 0, 300,  -1,  0, 301, 0, 0};
    tbl[1] = '{0, 0, 1,   5,  -1, 20,   6, 0, 1};
    tbl[2] = '{0, 1, 0,   7,   7,  2,   8, 1, 1};
    tbl[3] = '{1, 1, 0,  -1,  -1,  3,  16, 2, 1};

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].sel[0] != sel_to) begin
        do_reset();
        sel_to = tbl[i].sel[0];
      end
      run_cmd(tbl[i]);
    end
    do_reset();
    sel_to = 1'b0;

    // Command ignored while busy, then reset in the middle of RUN.
    @(negedge clk);
    cmd_valid = 1'b1; cp = 1'b0; toc = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_no_ack", 64'(ack), 64'(0));
    chk("busy_run_en", 64'(eng_en), 64'(1));
    randomize_ctrl();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");

    for (int i = 0; i < 20; i++) begin
      rv.sel = 0;
      rv.cp  = int'($urandom_range(0, 1));
      rv.toc = int'($urandom_range(0, 1));
      rv.d   = int'($urandom_range(0, 30));
      rv.r   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
      rv.xd  = int'($urandom_range(0, 5));
      model(rv.d, rv.r, MAIN_TO, rv.toc, len_m, err_m, ex_m);
      rv.len = len_m; rv.err = err_m; rv.ex = ex_m;
      run_cmd(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
